// File: rtl/sim_clk_pkg.sv
// Shared types and the phase comparison used by the phase-staggered clock divider.
// phase_high() decides whether an output sits in the high half of its period.
package sim_clk_pkg;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_BUSY,
        PS_DONE
    } ps_state_t;

    // High during the first half-period that starts at count value `off`.
    function automatic logic phase_high(
        input logic [31:0] cnt,
        input logic [31:0] off,
        input logic [31:0] divide
    );
        logic [31:0] pos;
        pos = (cnt + divide - (off % divide)) % divide;
        return pos < (divide >> 1);
    endfunction

endpackage

// File: rtl/sim_clk_ps_ctrl.sv
// Dynamic phase-shift handshake: accepts a request, moves the phase offset by one
// CLK cycle, then pulses done after a fixed wait.
module sim_clk_ps_ctrl
    import sim_clk_pkg::*;
#(
    parameter int DIVIDE  = 4,
    parameter int PS_WAIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      incdec,
    output logic [$clog2(DIVIDE)-1:0] off,
    output logic                      done
);

    localparam int CW = $clog2(DIVIDE);
    localparam int WW = (PS_WAIT > 1) ? $clog2(PS_WAIT) : 1;

    ps_state_t     state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [CW-1:0] off_nxt;
    logic          done_nxt;
    logic          accept;

    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        off_nxt   = off;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        case (state)
            PS_IDLE: accept = en;
            PS_BUSY: begin
                if (wait_cnt == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = PS_DONE;
                end else begin
                    wait_nxt = wait_cnt - WW'(1);
                end
            end
            // A request on the done cycle is taken, so back-to-back shifts land PS_WAIT+1 apart.
            PS_DONE: begin
                accept    = en;
                state_nxt = PS_IDLE;
            end
            default: state_nxt = PS_IDLE;
        endcase

        if (accept) begin
            state_nxt = PS_BUSY;
            wait_nxt  = WW'(PS_WAIT - 1);
            if (incdec)
                off_nxt = (off == CW'(DIVIDE - 1)) ? '0 : off + CW'(1);
            else
                off_nxt = (off == '0) ? CW'(DIVIDE - 1) : off - CW'(1);
        end
    end

    // NOTE: state registers use <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PS_IDLE;
            wait_cnt <= '0;
            off      <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            off      <= off_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: rtl/sim_clk_phase_gen.sv
// Multi-output phase-staggered clock divider with dynamic phase shift and lock flag.
// Output k is CLK/DIVIDE, 50% duty, starting at count (k*PHASE_STEP + ps_off) mod DIVIDE.
module sim_clk_phase_gen
    import sim_clk_pkg::*;
#(
    parameter int DIVIDE      = 4,
    parameter int NUM_OUT     = 4,
    parameter int PHASE_STEP  = 1,
    parameter int LOCK_CYCLES = 8,
    parameter int PS_WAIT     = 4
) (
    input  logic               CLK,
    input  logic               R,
    input  logic               PSEN,
    input  logic               PSINCDEC,
    output logic [NUM_OUT-1:0] CLKOUT,
    output logic               PSDONE,
    output logic               LOCKED
);

    localparam int CW = $clog2(DIVIDE);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] ps_off;
    logic [LW-1:0] lock_cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIVIDE - 1));

    always_ff @(posedge CLK) begin
        if (R)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // Lock counts whole output periods and never drops until reset.
    always_ff @(posedge CLK) begin
        if (R) begin
            lock_cnt <= '0;
            LOCKED   <= 1'b0;
        end else if (wrap && lock_cnt != LW'(LOCK_CYCLES)) begin
            lock_cnt <= lock_cnt + LW'(1);
            if (lock_cnt == LW'(LOCK_CYCLES - 1))
                LOCKED <= 1'b1;
        end
    end

    sim_clk_ps_ctrl #(
        .DIVIDE (DIVIDE),
        .PS_WAIT(PS_WAIT)
    ) u_ps_ctrl (
        .clk   (CLK),
        .rst   (R),
        .en    (PSEN),
        .incdec(PSINCDEC),
        .off   (ps_off),
        .done  (PSDONE)
    );

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        logic [31:0] off_k;
        logic        q;

        assign off_k = (32'(k) * 32'(PHASE_STEP) + 32'(ps_off)) % 32'(DIVIDE);

        always_ff @(posedge CLK) begin
            if (R)
                q <= 1'b0;
            else
                q <= phase_high(32'(cnt), off_k, 32'(DIVIDE));
        end

        assign CLKOUT[k] = q;
    end

endmodule

// File: tb/tb_sim_clk_phase_gen.sv
// Bench for sim_clk_phase_gen: an edge-count model checked every cycle, plus
// hand-computed waveform, lock, handshake and reset-mid-shift expectations.
module tb_sim_clk_phase_gen;

    localparam int D1 = 4, N1 = 4, S1 = 1, L1 = 8, W1 = 4;
    localparam int D2 = 2, N2 = 3, S2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          r, psen, psincdec;
    logic [N1-1:0] clkout;
    logic          psdone, locked;

    logic          r2;
    logic          psen2 = 1'b0;
    logic          psincdec2 = 1'b0;
    logic [N2-1:0] clkout2;
    logic          psdone2, locked2;

    sim_clk_phase_gen #(
        .DIVIDE(D1), .NUM_OUT(N1), .PHASE_STEP(S1), .LOCK_CYCLES(L1), .PS_WAIT(W1)
    ) dut (
        .CLK(clk), .R(r), .PSEN(psen), .PSINCDEC(psincdec),
        .CLKOUT(clkout), .PSDONE(psdone), .LOCKED(locked)
    );

    sim_clk_phase_gen #(
        .DIVIDE(D2), .NUM_OUT(N2), .PHASE_STEP(S2), .LOCK_CYCLES(L1), .PS_WAIT(W1)
    ) dut2 (
        .CLK(clk), .R(r2), .PSEN(psen2), .PSINCDEC(psincdec2),
        .CLKOUT(clkout2), .PSDONE(psdone2), .LOCKED(locked2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pmod(input int a, input int m);
        return ((a % m) + m) % m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model: edges since reset release, total phase offset, and last accepted shift.
    int            m_n, m_off, m_last, m_n2;
    bit            m_busy, m_valid;
    logic [N1-1:0] e_clk;
    logic [N2-1:0] e_clk2;
    logic          e_done, e_lock, e_lock2;

    task automatic model_step();
        if (r) begin
            m_n = 0; m_off = 0; m_last = -100; m_busy = 0;
            e_clk = '0; e_done = 1'b0; e_lock = 1'b0;
            m_valid = 1'b1;
        end else begin
            for (int k = 0; k < N1; k++)
                e_clk[k] = (pmod(m_n - k * S1 - m_off, D1) < D1 / 2);
            m_n++;
            e_lock = (m_n >= L1 * D1);
            e_done = m_busy && (m_n == m_last + W1);
            if (m_busy && m_n > m_last + W1)
                m_busy = 0;
            if (psen && !m_busy) begin
                m_off  = psincdec ? pmod(m_off + 1, D1) : pmod(m_off - 1, D1);
                m_last = m_n;
                m_busy = 1;
            end
        end
        if (r2) begin
            m_n2 = 0; e_clk2 = '0; e_lock2 = 1'b0;
        end else begin
            for (int k = 0; k < N2; k++)
                e_clk2[k] = (pmod(m_n2 - k * S2, D2) < D2 / 2);
            m_n2++;
            e_lock2 = (m_n2 >= L1 * D2);
        end
    endtask

    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("clkout", 32'(clkout), 32'(e_clk));
                check("psdone", 32'(psdone), 32'(e_done));
                check("locked", 32'(locked), 32'(e_lock));
                check("clkout2", 32'(clkout2), 32'(e_clk2));
                check("psdone2", 32'(psdone2), 32'(1'b0));
                check("locked2", 32'(locked2), 32'(e_lock2));
            end
        end
    end

    bit pat0[4] = '{1, 1, 0, 0};
    bit pat1[4] = '{0, 1, 1, 0};
    bit pat3[4] = '{1, 0, 0, 1};
    int pulses;

    initial begin
        r = 1'b1; r2 = 1'b1; psen = 1'b0; psincdec = 1'b0;
        tick(3);
        check("rst_clkout", 32'(clkout), 32'(0));
        check("rst_locked", 32'(locked), 32'(0));
        r = 1'b0; r2 = 1'b0;

        // Waveforms after reset release, both instances.
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("t1_clkout0", 32'(clkout[0]), 32'(pat0[i % 4]));
            check("t1_clkout1", 32'(clkout[1]), 32'(pat1[i % 4]));
            check("t1_clkout3", 32'(clkout[3]), 32'(pat3[i % 4]));
            check("t6_clkout2", 32'(clkout2), (i % 2 == 0) ? 32'(3'b101) : 32'(3'b010));
        end

        tick(23);
        check("t2_locked_e31", 32'(locked), 32'(0));
        tick(1);
        check("t2_locked_e32", 32'(locked), 32'(1));

        // Increment shift accepted at edge 33.
        psincdec = 1'b1; psen = 1'b1;
        tick(1);
        psen = 1'b0;
        tick(3);
        check("t3_psdone_a3", 32'(psdone), 32'(0));
        tick(1);
        check("t3_psdone_a4", 32'(psdone), 32'(1));
        check("t3_delayed_a4", 32'(clkout[0]), 32'(0));
        tick(1);
        check("t3_psdone_a5", 32'(psdone), 32'(0));
        check("t3_delayed_a5", 32'(clkout[0]), 32'(1));

        repeat (3) begin
            psen = 1'b1;
            tick(1);
            psen = 1'b0;
            tick(5);
        end
        tick(1);
        check("t3_restored_0", 32'(clkout[0]), 32'(1));
        tick(1);
        check("t3_restored_1", 32'(clkout[0]), 32'(1));
        tick(1);
        check("t3_restored_2", 32'(clkout[0]), 32'(0));
        check("t3_lock_held", 32'(locked), 32'(1));

        // Decrement with PSEN held for ten edges.
        psincdec = 1'b0; psen = 1'b1; pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (i == 9) psen = 1'b0;
            if (psdone === 1'b1) pulses++;
        end
        check("t4_accepts", 32'(pulses), 32'(2));

        // Reset two edges into a shift, then a fresh request.
        psincdec = 1'b1; psen = 1'b1;
        tick(1);
        psen = 1'b0;
        tick(1);
        r = 1'b1;
        tick(1);
        check("t5_rst_clkout", 32'(clkout), 32'(0));
        check("t5_rst_locked", 32'(locked), 32'(0));
        check("t5_rst_psdone", 32'(psdone), 32'(0));
        r = 1'b0; psen = 1'b1;
        tick(1);
        psen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t5_no_psdone", 32'(psdone), 32'(0));
        end
        tick(1);
        check("t5_fresh_psdone", 32'(psdone), 32'(1));

        tick(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
